// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq: request handshake with operands/opcode, result handshake with flags.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: 1-edge logic/arith/shift ops, WIDTH+1-edge iterative MUL/MULH/DIVU/REMU.
// One op in flight; the result is held in DONE until out_ready, and no request is taken meanwhile.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_END = (SHW+1)'(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_MULH = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;
  localparam logic [3:0] OP_REMU = 4'd11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       flags_q, flags_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   alu_wide;
  logic [SHW-1:0]   shamt;
  logic             alu_carry, alu_ovf, alu_dz;

  always_comb begin
    alu_res   = '0;
    alu_wide  = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_dz    = 1'b0;
    shamt     = bus.b[SHW-1:0];
    case (bus.op)
      OP_ADD: begin
        alu_wide  = {1'b0, bus.a} + {1'b0, bus.b};
        alu_res   = alu_wide[WIDTH-1:0];
        alu_carry = alu_wide[WIDTH];
        alu_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = bus.a - bus.b;
        alu_carry = bus.a < bus.b;
        alu_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_SHL: alu_res = bus.a << shamt;
      OP_SHR: alu_res = bus.a >> shamt;
      OP_SRA: alu_res = $unsigned($signed(bus.a) >>> shamt);
      // Only reached for a zero divisor; nonzero divisors go through BUSY.
      OP_DIVU: begin
        alu_res = '1;
        alu_dz  = 1'b1;
      end
      OP_REMU: begin
        alu_res = bus.a;
        alu_dz  = 1'b1;
      end
      default: alu_res = '0;
    endcase
  end

  logic             is_mul_q;
  logic [WIDTH:0]   mul_sum, div_try;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo, iter_res;

  assign is_mul_q = (op_q == OP_MUL) || (op_q == OP_MULH);

  // hi/lo is {partial product, multiplier} for MUL or {remainder, dividend->quotient} for DIV.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_try = {hi_q, lo_q[WIDTH-1]};
    div_ge  = div_try >= {1'b0, opnd_q};
    if (is_mul_q) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? WIDTH'(div_try - {1'b0, opnd_q}) : div_try[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end
    case (op_q)
      OP_MULH, OP_REMU: iter_res = step_hi;
      default:          iter_res = step_lo;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d  = bus.op;
          cnt_d = '0;
          hi_d  = '0;
          if (bus.op == OP_MUL || bus.op == OP_MULH) begin
            state_d = BUSY;
            opnd_d  = bus.a;
            lo_d    = bus.b;
          end else if ((bus.op == OP_DIVU || bus.op == OP_REMU) && bus.b != '0) begin
            state_d = BUSY;
            opnd_d  = bus.b;
            lo_d    = bus.a;
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            flags_d  = {alu_dz, alu_ovf, alu_carry, alu_res[WIDTH-1], alu_res == '0};
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        hi_d  = step_hi;
        lo_d  = step_lo;
        if (cnt_d == CNT_END) begin
          state_d  = DONE;
          result_d = iter_res;
          flags_d  = {1'b0, 1'b0, is_mul_q && (step_hi != '0), iter_res[WIDTH-1], iter_res == '0};
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq (WIDTH = 8) against an arithmetic reference model.
module tb_alu_seq;
  localparam int W   = 8;
  localparam int TMO = 40;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output logic [4:0] f, output int lat);
    int   ua;
    int   ub;
    int   sa;
    int   sb;
    int   full;
    logic dz;
    logic ovf;
    logic c;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    dz = 0; ovf = 0; c = 0; lat = 1; full = 0;
    case (op)
      4'd0: begin full = ua + ub; r = full[7:0]; c = full > 255; ovf = (sa + sb > 127) || (sa + sb < -128); end
      4'd1: begin full = ua - ub; r = full[7:0]; c = ua < ub; ovf = (sa - sb > 127) || (sa - sb < -128); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin full = ua << b[2:0]; r = full[7:0]; end
      4'd6: begin full = ua >> b[2:0]; r = full[7:0]; end
      4'd7: begin full = sa >>> b[2:0]; r = full[7:0]; end
      4'd8, 4'd9: begin
        full = ua * ub; lat = 9; c = full > 255;
        r = (op == 4'd8) ? full[7:0] : full[15:8];
      end
      4'd10: if (ub == 0) begin r = 8'hFF; dz = 1; end else begin full = ua / ub; r = full[7:0]; lat = 9; end
      4'd11: if (ub == 0) begin r = a; dz = 1; end else begin full = ua % ub; r = full[7:0]; lat = 9; end
      default: r = 8'h00;
    endcase
    f = {dz, ovf, c, r[7], r == 8'h00};
  endfunction

  // Issue one request (called #1 after an edge), scramble inputs after acceptance, wait and consume.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output logic [4:0] fl, output int lat, output logic rdy);
    rdy = bus.in_ready;
    bus.in_valid = 1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.in_valid = 0; bus.a = 8'($urandom); bus.b = 8'($urandom); bus.op = 4'($urandom);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < TMO) begin
      @(posedge clk); #1; lat++;
    end
    res = bus.result; fl = bus.flags;
    bus.out_ready = 1;
    @(posedge clk); #1;
    bus.out_ready = 0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.result !== 8'h00) begin failures++; $display("FAIL reset_result got=%h exp=00", bus.result); end
    checks++; if (bus.flags !== 5'h00) begin failures++; $display("FAIL reset_flags got=%b exp=00000", bus.flags); end
    bus.in_valid = 1; bus.op = 4'd0; bus.a = 8'd1; bus.b = 8'd1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_no_accept got=%b exp=0", bus.out_valid); end
    bus.in_valid = 0;
    rst = 0;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [4:0] f;
    int         lat;
  } vec_t;

  task automatic test_directed;
    vec_t       v[10];
    logic [7:0] res;
    logic [4:0] fl;
    int         lat;
    logic       rdy;
    v[0] = '{4'd0,  8'h7F, 8'h01, 8'h80, 5'b01010, 1};
    v[1] = '{4'd1,  8'h00, 8'h01, 8'hFF, 5'b00110, 1};
    v[2] = '{4'd7,  8'h80, 8'h03, 8'hF0, 5'b00010, 1};
    v[3] = '{4'd8,  8'd200, 8'd3, 8'h58, 5'b00100, 9};
    v[4] = '{4'd9,  8'd200, 8'd3, 8'h02, 5'b00100, 9};
    v[5] = '{4'd10, 8'd100, 8'd7, 8'h0E, 5'b00000, 9};
    v[6] = '{4'd11, 8'd100, 8'd7, 8'h02, 5'b00000, 9};
    v[7] = '{4'd10, 8'h55, 8'h00, 8'hFF, 5'b10010, 1};
    v[8] = '{4'd11, 8'h55, 8'h00, 8'h55, 5'b10000, 1};
    v[9] = '{4'd13, 8'h12, 8'h34, 8'h00, 5'b00001, 1};
    for (int i = 0; i < 10; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, res, fl, lat, rdy);
      checks++; if (res !== v[i].r) begin failures++; $display("FAIL directed[%0d] result got=%h exp=%h", i, res, v[i].r); end
      checks++; if (fl !== v[i].f) begin failures++; $display("FAIL directed[%0d] flags got=%b exp=%b", i, fl, v[i].f); end
      checks++; if (lat != v[i].lat) begin failures++; $display("FAIL directed[%0d] latency got=%0d exp=%0d", i, lat, v[i].lat); end
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL directed[%0d] in_ready got=%b exp=1", i, rdy); end
    end
  endtask

  task automatic test_random;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] er;
    logic [4:0] fl;
    logic [4:0] ef;
    int         lat;
    int         elat;
    logic       rdy;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      model(op, a, b, er, ef, elat);
      run_op(op, a, b, res, fl, lat, rdy);
      checks++; if (res !== er) begin failures++; $display("FAIL random[%0d] op=%0d a=%h b=%h result got=%h exp=%h", i, op, a, b, res, er); end
      checks++; if (fl !== ef) begin failures++; $display("FAIL random[%0d] op=%0d a=%h b=%h flags got=%b exp=%b", i, op, a, b, fl, ef); end
      checks++; if (lat != elat) begin failures++; $display("FAIL random[%0d] op=%0d latency got=%0d exp=%0d", i, op, lat, elat); end
      checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL random[%0d] in_ready got=%b exp=1", i, rdy); end
    end
  endtask

  task automatic test_backpressure;
    int         n;
    logic [7:0] res;
    logic [4:0] fl;
    int         lat;
    logic       rdy;
    bus.in_valid = 1; bus.op = 4'd0; bus.a = 8'h10; bus.b = 8'h20;
    @(posedge clk); #1;
    bus.in_valid = 0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < TMO) begin
      @(posedge clk); #1; n++;
    end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_done got=%b exp=1", bus.out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.result !== 8'h30) begin failures++; $display("FAIL bp_hold[%0d] result got=%h exp=30", i, bus.result); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold[%0d] in_ready got=%b exp=0", i, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold[%0d] out_valid got=%b exp=1", i, bus.out_valid); end
    end
    bus.out_ready = 1;
    @(posedge clk); #1;
    bus.out_ready = 0;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release out_valid got=%b exp=0", bus.out_valid); end
    run_op(4'd4, 8'hA5, 8'h0F, res, fl, lat, rdy);
    checks++; if (res !== 8'hAA) begin failures++; $display("FAIL bp_next result got=%h exp=aa", res); end
    checks++; if (lat != 1) begin failures++; $display("FAIL bp_next latency got=%0d exp=1", lat); end
  endtask

  task automatic test_reset_abort;
    int         seen;
    logic [7:0] res;
    logic [4:0] fl;
    int         lat;
    logic       rdy;
    bus.in_valid = 1; bus.op = 4'd8; bus.a = 8'd200; bus.b = 8'd3;
    @(posedge clk); #1;
    bus.in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL abort_busy in_ready=%b out_valid=%b exp=0/0", bus.in_ready, bus.out_valid);
    end
    rst = 1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL abort_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.result !== 8'h00) begin failures++; $display("FAIL abort_result got=%h exp=00", bus.result); end
    @(posedge clk); #1;
    rst = 0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL abort_no_result out_valid cycles got=%0d exp=0", seen); end
    run_op(4'd0, 8'd1, 8'd1, res, fl, lat, rdy);
    checks++; if (res !== 8'h02) begin failures++; $display("FAIL abort_add result got=%h exp=02", res); end
    checks++; if (fl !== 5'b00000) begin failures++; $display("FAIL abort_add flags got=%b exp=00000", fl); end
    checks++; if (lat != 1) begin failures++; $display("FAIL abort_add latency got=%0d exp=1", lat); end
  endtask

  initial begin
    checks = 0; failures = 0;
    clk = 0; rst = 1;
    bus.in_valid = 0; bus.out_ready = 0; bus.a = '0; bus.b = '0; bus.op = '0;
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_abort;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; legal range 4..32.
REQ-002 Derived constant SHW = $clog2(WIDTH), the shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a  input  WIDTH  operand A, unsigned unless op states otherwise.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 SRA, 8 MUL (low half), 9 MULH (unsigned high half), 10 DIVU, 11 REMU; 12..15 reserved.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 flags  output  5  registered flags {dz, ovf, carry, neg, zero}, bit 4 first.

Function
REQ-014 Handshake: a request is accepted on a rising edge where in_valid and in_ready are both 1; a result is consumed where out_valid and out_ready are both 1.
REQ-015 FSM states are IDLE, BUSY and DONE; in_ready = (state == IDLE) and out_valid = (state == DONE), both decoded from the state register only.
REQ-016 Operands and op are captured at acceptance; later changes to a, b or op have no effect until the next acceptance.
REQ-017 Single-cycle ops (0..7, 12..15): IDLE -> DONE on acceptance; out_valid rises on the edge after the accepting edge.
REQ-018 ADD: result = (a+b) mod 2^WIDTH; carry = carry-out; ovf = signed overflow.
REQ-019 SUB: result = (a-b) mod 2^WIDTH; carry = borrow (a < b unsigned); ovf = signed overflow.
REQ-020 AND, OR, XOR: bitwise; carry = 0, ovf = 0.
REQ-021 SHL, SHR, SRA: shift amount is b[SHW-1:0]; SRA is arithmetic (sign fill); carry = 0, ovf = 0.
REQ-022 Reserved ops: result = 0, zero = 1, all other flags 0.
REQ-023 MUL and MULH: IDLE -> BUSY on acceptance; iterative shift-add, one multiplier bit per cycle, exactly WIDTH BUSY cycles, then DONE.
REQ-024 MUL/MULH timing: out_valid rises exactly WIDTH+1 edges after the accepting edge.
REQ-025 MUL/MULH result: MUL returns the low WIDTH bits of the 2*WIDTH product, MULH the high WIDTH bits; carry = 1 iff the high half is nonzero.
REQ-026 DIVU and REMU: iterative restoring division, one quotient bit per cycle, same WIDTH-cycle BUSY phase and latency as MUL.
REQ-027 DIVU/REMU result: DIVU returns the quotient, REMU the remainder.
REQ-028 Divide by zero: DIVU/REMU with b == 0 is detected at acceptance and skips BUSY (IDLE -> DONE, latency 1).
REQ-029 Divide-by-zero result: DIVU returns all-ones, REMU returns a, dz = 1.
REQ-030 dz = 0 for every other case.
REQ-031 For all ops, neg = result[WIDTH-1] and zero = (result == 0); ovf = 0 except for ADD/SUB.
REQ-032 DONE holds result and flags stable until consumed; DONE -> IDLE on the consuming edge.
REQ-033 No request is accepted in BUSY or DONE (no overlap); throughput is at most one op per 2 cycles for single-cycle ops and one per WIDTH+2 cycles for multi-cycle ops.
REQ-034 The internal BUSY iteration counter is SHW+1 bits wide and terminates at WIDTH; it does not wrap.

Reset
REQ-035 While rst = 1: state = IDLE, in_ready = 1, out_valid = 0, result = 0, flags = 0, iteration counter and partial product/remainder registers = 0.
REQ-036 rst asserted during BUSY or DONE aborts the operation with no result ever presented.
REQ-037 After rst deasserts, the first edge can accept a request.

Verification (WIDTH = 8)
REQ-038 ADD a=0x7F b=0x01 -> result 0x80, flags ovf=1 neg=1 carry=0 zero=0, with out_valid exactly 1 edge after acceptance.
REQ-039 SUB a=0x00 b=0x01 -> result 0xFF, carry=1 neg=1 ovf=0; then SRA a=0x80 b=0x03 -> 0xF0.
REQ-040 MUL a=200 b=3 -> result 0x58, carry=1, out_valid exactly 9 edges after acceptance; MULH with the same operands -> 0x02.
REQ-041 DIVU a=100 b=7 -> 0x0E; REMU a=100 b=7 -> 0x02; DIVU a=0x55 b=0 -> 0xFF with dz=1 and latency 1; REMU a=0x55 b=0 -> 0x55 with dz=1.
REQ-042 Hold out_ready = 0 for 5 cycles after ADD 0x10+0x20 completes -> result stays 0x30 and in_ready stays 0 throughout; one cycle of out_ready -> IDLE; the next request is accepted.
REQ-043 Assert rst on the 4th BUSY cycle of a MUL -> out_valid never rises for that MUL, in_ready = 1 immediately, and a subsequent ADD 1+1 returns 0x02.
